// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter that shares one UART transmitter among N_REQ requesters.
// Accepts one byte at a time, strobes the transmitter, follows tx_busy, then holds off for a fixed gap.
module uart_tx_arb #(
  parameter int N_REQ      = 4,
  parameter int GAP_CYCLES = 16,
  parameter int START_TO   = 4,
  localparam int ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               tx_clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         tx_data,
  output logic               tx_start,
  input  logic               tx_busy,
  output logic [ID_W-1:0]    grant_id,
  output logic               active,
  output logic               start_err
);

  // state     | meaning
  // IDLE      | searching for a valid requester from ptr upward
  // LOAD      | tx_start strobe, byte already on tx_data
  // WAIT_BUSY | waiting up to START_TO cycles for tx_busy to rise
  // SHIFT     | transmitter is shifting the frame
  // GAP       | forced idle time before the next acceptance
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    WAIT_BUSY = 3'd2,
    SHIFT     = 3'd3,
    GAP       = 3'd4
  } state_t;

  localparam int         SUM_W    = ID_W + 1;
  localparam logic [3:0] TO_LAST  = 4'(START_TO - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   ptr_nxt;
  logic [3:0]        to_cnt;
  logic [7:0]        gap_cnt;
  logic [ID_W-1:0]   win_id;
  logic              win_found;
  logic [SUM_W-1:0]  scan_sum;
  logic [ID_W-1:0]   scan_idx;
  logic              accept;
  logic              to_hit;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    win_id    = '0;
    win_found = 1'b0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan_sum = {1'b0, ptr} + SUM_W'(k);
      if (scan_sum >= SUM_W'(N_REQ)) begin
        scan_sum = scan_sum - SUM_W'(N_REQ);
      end
      scan_idx = scan_sum[ID_W-1:0];
      if (req_valid[scan_idx]) begin
        win_id    = scan_idx;
        win_found = 1'b1;
      end
    end
  end

  assign ptr_nxt = (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + 1'b1;
  assign accept  = (state == IDLE) && win_found;
  assign to_hit  = (state == WAIT_BUSY) && !tx_busy && (to_cnt == TO_LAST);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (win_found) state_nxt = LOAD;
      LOAD:      state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = SHIFT;
        end else if (to_cnt == TO_LAST) begin
          state_nxt = GAP;
        end
      end
      SHIFT:     if (!tx_busy) state_nxt = GAP;
      GAP:       if (gap_cnt == GAP_LAST) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Gate with rst_n so nothing is handed over while the block is held in reset.
  assign req_ready = (rst_n && accept) ? ({{(N_REQ-1){1'b0}}, 1'b1} << win_id) : '0;
  assign active    = (state != IDLE);

  always_ff @(posedge tx_clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      tx_start  <= 1'b0;
      start_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      tx_start  <= accept;
      start_err <= to_hit;
    end
  end

  always_ff @(posedge tx_clk) begin
    if (!rst_n) begin
      ptr      <= '0;
      tx_data  <= 8'h00;
      grant_id <= '0;
    end else if (accept) begin
      ptr      <= ptr_nxt;
      tx_data  <= req_data[8*win_id +: 8];
      grant_id <= win_id;
    end
  end

  // Both counters are held at zero outside their own state, so entry always starts from zero.
  always_ff @(posedge tx_clk) begin
    if (!rst_n) begin
      to_cnt  <= '0;
      gap_cnt <= '0;
    end else begin
      if (state != WAIT_BUSY) begin
        to_cnt <= '0;
      end else if (!tx_busy) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (state != GAP) begin
        gap_cnt <= '0;
      end else begin
        gap_cnt <= gap_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed frame table, mid-frame reset, a 2-requester gap check,
// and a randomized run checked cycle by cycle against an event-time reference model.
module tb_uart_tx_arb;
  localparam int N  = 4;
  localparam int G  = 16;
  localparam int TO = 4;

  logic tx_clk = 1'b0;
  always #5 tx_clk = ~tx_clk;

  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_start;
  logic           tx_busy;
  logic [1:0]     grant_id;
  logic           active;
  logic           start_err;

  logic [1:0]  valid2;
  logic [15:0] data2;
  logic [1:0]  ready2;
  logic [7:0]  tx_data2;
  logic        tx_start2;
  logic        busy2;
  logic [0:0]  grant_id2;
  logic        active2;
  logic        start_err2;

  uart_tx_arb #(.N_REQ(N), .GAP_CYCLES(G), .START_TO(TO)) dut (
    .tx_clk(tx_clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .grant_id(grant_id), .active(active), .start_err(start_err)
  );

  uart_tx_arb #(.N_REQ(2), .GAP_CYCLES(1), .START_TO(TO)) dut2 (
    .tx_clk(tx_clk), .rst_n(rst_n), .req_valid(valid2), .req_data(data2),
    .req_ready(ready2), .tx_data(tx_data2), .tx_start(tx_start2), .tx_busy(busy2),
    .grant_id(grant_id2), .active(active2), .start_err(start_err2)
  );

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    int          d;    // cycles after tx_start when busy rises; > TO means never
    int          b;    // busy length in cycles
    int          gid;
    bit          err;
  } frame_t;

  frame_t tbl[12];

  int checks = 0;
  int failures = 0;
  int t;
  int m_ptr, m_gid, m_l, m_err, m_bfrom, m_bto, m_idle_at;
  logic [7:0] m_data;
  logic [N-1:0]   cur_valid;
  logic [8*N-1:0] cur_data;
  logic cur_rst;
  bit   rand_mode;
  bit   accepted;
  bit   saw_err;
  int   next_d, next_b;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s t=%0d got=%0h expected=%0h", nm, t, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s t=%0d bound expired", nm, t);
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic step();
    logic [N-1:0] exp_rdy;
    bit idle, found;
    int w, idx, d, b;
    rst_n = cur_rst;
    if (rand_mode) begin
      req_valid = N'($urandom) & N'($urandom);
      req_data  = $urandom;
    end else begin
      req_valid = cur_valid;
      req_data  = cur_data;
    end
    tx_busy = (t >= m_bfrom) && (t <= m_bto);
    #1;
    idle  = (t >= m_idle_at);
    found = 1'b0;
    w     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (!found && req_valid[idx[1:0]]) begin
        found = 1'b1;
        w     = idx;
      end
    end
    exp_rdy = (idle && cur_rst && found) ? (4'b0001 << w) : 4'b0000;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("tx_start",  32'(tx_start),  32'(t == m_l));
    chk("start_err", 32'(start_err), 32'(t == m_err));
    chk("active",    32'(active),    32'(!idle));
    chk("tx_data",   32'(tx_data),   32'(m_data));
    chk("grant_id",  32'(grant_id),  32'(m_gid));
    if (start_err === 1'b1) saw_err = 1'b1;
    if (!cur_rst) begin
      m_ptr = 0; m_gid = 0; m_data = 8'h00;
      m_l = -1; m_err = -1; m_bfrom = -1; m_bto = -2;
      m_idle_at = t + 1;
    end else if (exp_rdy != 0) begin
      accepted = 1'b1;
      m_data = req_data[8*w +: 8];
      m_gid  = w;
      m_ptr  = (w + 1) % N;
      m_l    = t + 1;
      if (rand_mode) begin
        d = int'($urandom_range(1, TO + 2));
        b = int'($urandom_range(1, 12));
      end else begin
        d = next_d;
        b = next_b;
      end
      if (d > TO) begin
        m_err = m_l + TO + 1;
        m_bfrom = -1; m_bto = -2;
        m_idle_at = m_l + TO + 1 + G;
      end else begin
        m_err = -1;
        m_bfrom = m_l + d;
        m_bto = m_l + d + b - 1;
        m_idle_at = m_l + d + b + 1 + G;
      end
    end
    @(negedge tx_clk);
    t++;
  endtask

  task automatic wait_accept(input string nm);
    int n;
    n = 0;
    accepted = 1'b0;
    while (!accepted && n < 300) begin
      step();
      n++;
    end
    if (!accepted) fail_now(nm);
  endtask

  task automatic run_frame(input int i);
    int n;
    cur_valid = tbl[i].valid;
    cur_data  = tbl[i].data;
    next_d    = tbl[i].d;
    next_b    = tbl[i].b;
    saw_err   = 1'b0;
    wait_accept($sformatf("frame%0d_accept", i));
    chk($sformatf("frame%0d_grant", i), 32'(grant_id), 32'(tbl[i].gid));
    chk($sformatf("frame%0d_byte", i), 32'(tx_data), 32'(tbl[i].data[8*tbl[i].gid +: 8]));
    n = 0;
    while (t < m_idle_at && n < 400) begin
      step();
      n++;
    end
    if (t < m_idle_at) fail_now($sformatf("frame%0d_idle", i));
    chk($sformatf("frame%0d_err", i), 32'(saw_err), 32'(tbl[i].err));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0d time limit reached", t);
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int n;
    rst_n = 1'b0; cur_rst = 1'b0; req_valid = '0; req_data = '0; tx_busy = 1'b0;
    valid2 = '0; data2 = '0; busy2 = 1'b0;
    cur_valid = '0; cur_data = '0; rand_mode = 1'b0; saw_err = 1'b0;
    tbl[0]  = '{4'b1111, 32'h13121110, 1, 3, 0, 1'b0};
    tbl[1]  = '{4'b1111, 32'h13121110, 2, 1, 1, 1'b0};
    tbl[2]  = '{4'b1111, 32'h13121110, 1, 5, 2, 1'b0};
    tbl[3]  = '{4'b1111, 32'h13121110, 3, 2, 3, 1'b0};
    tbl[4]  = '{4'b1111, 32'h13121110, 1, 2, 0, 1'b0};
    tbl[5]  = '{4'b0100, 32'h13A51110, 1, 10, 2, 1'b0};
    tbl[6]  = '{4'b1000, 32'h13121110, 1, 4, 3, 1'b0};
    tbl[7]  = '{4'b1001, 32'h13121110, 2, 3, 0, 1'b0};
    tbl[8]  = '{4'b1001, 32'h13121110, 1, 2, 3, 1'b0};
    tbl[9]  = '{4'b1111, 32'h13121110, 99, 1, 0, 1'b1};
    tbl[10] = '{4'b1111, 32'h13121110, 1, 2, 1, 1'b0};
    tbl[11] = '{4'b1110, 32'h33221100, 2, 6, 1, 1'b0};

    repeat (3) @(posedge tx_clk);
    @(negedge tx_clk);
    t = 0;
    m_ptr = 0; m_gid = 0; m_data = 8'h00;
    m_l = -1; m_err = -1; m_bfrom = -1; m_bto = -2; m_idle_at = 0;
    cur_rst = 1'b1;
    repeat (3) step();

    for (int i = 0; i <= 10; i++) run_frame(i);

    // Reset in the middle of SHIFT with tx_busy high.
    cur_valid = 4'b0100; cur_data = 32'h13A51110; next_d = 1; next_b = 10;
    wait_accept("midrst_accept");
    cur_valid = '0;
    repeat (4) step();
    chk("midrst_busy_high", 32'(tx_busy), 32'(1));
    cur_valid = 4'b1111;
    cur_rst = 1'b0;
    step();
    cur_rst = 1'b1;
    cur_valid = '0;
    chk("midrst_tx_data", 32'(tx_data), 32'(0));
    chk("midrst_grant", 32'(grant_id), 32'(0));
    chk("midrst_active", 32'(active), 32'(0));
    chk("midrst_tx_start", 32'(tx_start), 32'(0));
    step();
    run_frame(11);

    // Two requesters, one-cycle gap.
    valid2 = 2'b01; data2 = 16'h775A; busy2 = 1'b0;
    got = 1'b0; n = 0;
    while (!got && n < 20) begin
      #1;
      if (ready2 == 2'b01) got = 1'b1;
      step();
      n++;
    end
    if (!got) fail_now("gap1_accept");
    chk("gap1_tx_start", 32'(tx_start2), 32'(1));
    chk("gap1_tx_data", 32'(tx_data2), 32'(8'h5A));
    chk("gap1_grant", 32'(grant_id2), 32'(0));
    busy2 = 1'b1;
    repeat (3) step();
    busy2 = 1'b0;
    #1; chk("gap1_ready_fall", 32'(ready2), 32'(0));
    step();
    #1; chk("gap1_ready_gap", 32'(ready2), 32'(0));
    chk("gap1_active_gap", 32'(active2), 32'(1));
    step();
    #1; chk("gap1_ready_idle", 32'(ready2), 32'(2'b01));
    valid2 = 2'b00;
    step();

    rand_mode = 1'b1;
    repeat (2500) step();
    rand_mode = 1'b0;
    cur_valid = '0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
